// File: rtl/pc_unit.sv
// Program counter with jump redirect, post-redirect flush window and halt.
// Three-state controller: RUN, FLUSH, HALT.
module pc_unit #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          PC_INC       = 1,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        is_jmp_op,
    input  logic        taken,
    input  logic [15:0] jmp_target,
    output logic [15:0] pc,
    output logic        flush,
    output logic        halted,
    output logic [15:0] branch_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [15:0] INC       = 16'(PC_INC);
    localparam logic [3:0]  CNT_START = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        redirect;
    logic [15:0] pc_next;

    assign redirect = is_jmp_op & taken;
    // Modulo-2^16 increment: the carry out is dropped on purpose.
    assign pc_next  = pc + INC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 4'd0;
            pc           <= RESET_PC;
            flush        <= 1'b0;
            halted       <= 1'b0;
            branch_count <= 16'h0000;
        end else begin
            unique case (state)
                RUN: begin
                    // A same-cycle halt belongs to a squashed younger op.
                    if (redirect) begin
                        state <= FLUSH;
                        cnt   <= CNT_START;
                        pc    <= jmp_target;
                        flush <= 1'b1;
                        if (branch_count != 16'hFFFF)
                            branch_count <= branch_count + 16'd1;
                    end else if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_next;
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        pc <= pc_next;
                        if (cnt == 4'd0) begin
                            state <= RUN;
                            flush <= 1'b0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                HALT: begin
                    flush  <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    flush  <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: run, redirect, flush, stall, halt, wrap.
// Expected values are hand-computed constants.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        is_jmp_op;
    logic        taken;
    logic [15:0] jmp_target;
    logic [15:0] pc;
    logic        flush;
    logic        halted;
    logic [15:0] branch_count;

    int n_checks;
    int n_errors;

    pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .is_jmp_op    (is_jmp_op),
        .taken        (taken),
        .jmp_target   (jmp_target),
        .pc           (pc),
        .flush        (flush),
        .halted       (halted),
        .branch_count (branch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] e_pc,
                             input logic e_fl, input logic e_h,
                             input logic [15:0] e_bc);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".flush"}, 32'(flush), 32'(e_fl));
        check({tag, ".halted"}, 32'(halted), 32'(e_h));
        check({tag, ".bc"}, 32'(branch_count), 32'(e_bc));
    endtask

    task automatic jump(input logic [15:0] t);
        is_jmp_op  = 1'b1;
        taken      = 1'b1;
        jmp_target = t;
    endtask

    task automatic no_jump();
        is_jmp_op  = 1'b0;
        taken      = 1'b0;
        jmp_target = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        halt       = 1'b0;
        no_jump();

        #2;
        chk_state("rst", 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Free run 0..5
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_state($sformatf("run%0d", i), 16'(i), 1'b0, 1'b0, 16'h0000);
        end

        // Redirect at pc=5 to 0x40
        jump(16'h0040);
        step();
        chk_state("jmp40", 16'h0040, 1'b1, 1'b0, 16'h0001);
        no_jump();
        step();
        chk_state("fl41", 16'h0041, 1'b1, 1'b0, 16'h0001);
        step();
        chk_state("fl42", 16'h0042, 1'b0, 1'b0, 16'h0001);

        // Redirect, stall inside FLUSH, second redirect ignored
        jump(16'h0080);
        step();
        chk_state("jmp80", 16'h0080, 1'b1, 1'b0, 16'h0002);
        jump(16'h0100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("stl%0d", i), 16'h0080, 1'b1, 1'b0, 16'h0002);
        end
        stall = 1'b0;
        step();
        chk_state("fl81", 16'h0081, 1'b1, 1'b0, 16'h0002);
        step();
        chk_state("fl82", 16'h0082, 1'b0, 1'b0, 16'h0002);
        no_jump();

        // Non-redirect jump encodings
        is_jmp_op = 1'b1;
        taken     = 1'b0;
        step();
        chk_state("nt", 16'h0083, 1'b0, 1'b0, 16'h0002);
        is_jmp_op = 1'b0;
        taken     = 1'b1;
        step();
        chk_state("tk_only", 16'h0084, 1'b0, 1'b0, 16'h0002);
        no_jump();

        // Stall in RUN
        stall = 1'b1;
        step();
        chk_state("run_stl", 16'h0084, 1'b0, 1'b0, 16'h0002);
        stall = 1'b0;

        // Halt with redirect: redirect wins; halt ignored during FLUSH
        halt = 1'b1;
        jump(16'h0200);
        step();
        chk_state("hjmp", 16'h0200, 1'b1, 1'b0, 16'h0003);
        no_jump();
        step();
        chk_state("hfl1", 16'h0201, 1'b1, 1'b0, 16'h0003);
        step();
        chk_state("hfl2", 16'h0202, 1'b0, 1'b0, 16'h0003);

        // halt now seen in RUN
        step();
        chk_state("hlt", 16'h0202, 1'b0, 1'b1, 16'h0003);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jump(16'(16'h0300 + i));
            stall = i[0];
            step();
        end
        chk_state("hfrz", 16'h0202, 1'b0, 1'b1, 16'h0003);
        no_jump();
        stall = 1'b0;

        // Async reset out of HALT, between edges
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_state("arst_h", 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_state("post_h", 16'h0001, 1'b0, 1'b0, 16'h0000);

        // Async reset mid-FLUSH
        jump(16'h0500);
        step();
        chk_state("jmp500", 16'h0500, 1'b1, 1'b0, 16'h0001);
        no_jump();
        #2;
        reset = 1'b1;
        #1;
        chk_state("arst_f", 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_state("post_f", 16'h0001, 1'b0, 1'b0, 16'h0000);

        // Wrap through 0xFFFF
        jump(16'hFFFE);
        step();
        chk_state("wr0", 16'hFFFE, 1'b1, 1'b0, 16'h0001);
        no_jump();
        step();
        chk_state("wr1", 16'hFFFF, 1'b1, 1'b0, 16'h0001);
        step();
        chk_state("wr2", 16'h0000, 1'b0, 1'b0, 16'h0001);
        step();
        chk_state("wr3", 16'h0001, 1'b0, 1'b0, 16'h0001);

        // Many redirects counted
        for (int i = 0; i < 1000; i++) begin
            jump(16'(i));
            step();
            no_jump();
            step();
            step();
        end
        check("bc1001", 32'(branch_count), 32'd1001);
        check("pc_loop", 32'(pc), 32'd1001);

        // Saturation: preload near the top, then redirect past it
        @(negedge clk);
        force dut.branch_count = 16'hFFFE;
        #1;
        release dut.branch_count;
        jump(16'h0010);
        step();
        check("sat1", 32'(branch_count), 32'h0000FFFF);
        no_jump();
        step();
        step();
        jump(16'h0020);
        step();
        check("sat2", 32'(branch_count), 32'h0000FFFF);
        check("sat2pc", 32'(pc), 32'h00000020);
        no_jump();
        step();
        step();
        check("sat_end", 32'(flush), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_INC, default 1, PC increment per advancing cycle (word-addressed).
REQ-003 Parameter FLUSH_CYCLES, default 2, number of advancing cycles flush stays high after a redirect; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  pipeline hold request; PC does not advance while high.
REQ-007 halt  input  1  halt request from decode.
REQ-008 is_jmp_op  input  1  instruction in execute is a jump.
REQ-009 taken  input  1  condition-check result for that jump.
REQ-010 jmp_target  input  16  jump destination address.
REQ-011 pc  output  16  current fetch address, registered.
REQ-012 flush  output  1  squash younger IF/ID instructions, registered.
REQ-013 halted  output  1  unit is in HALT, registered.
REQ-014 branch_count  output  16  number of redirects taken since reset, registered.

Function
REQ-015 The unit SHALL implement three states: RUN, FLUSH and HALT.
REQ-016 redirect SHALL be defined as is_jmp_op & taken; taken with is_jmp_op=0 is ignored.
REQ-017 In RUN, redirect SHALL have top priority.
- Next cycle: pc=jmp_target, state=FLUSH, flush=1, flush counter=FLUSH_CYCLES-1.
- Applies regardless of stall.
REQ-018 In RUN without redirect:
- halt=1: state=HALT, pc held.
- Else stall=0: pc=pc+PC_INC.
- Else: pc held.
REQ-019 In FLUSH, flush SHALL stay 1 and redirect and halt inputs SHALL be ignored.
REQ-020 In FLUSH with stall=0:
- pc SHALL increment by PC_INC.
- If counter==0, state SHALL return to RUN with flush=0 on the next cycle.
- Otherwise counter SHALL decrement.
REQ-021 In FLUSH with stall=1, pc and counter SHALL hold, so flush spans exactly FLUSH_CYCLES non-stalled cycles.
REQ-022 In HALT, pc SHALL be frozen, flush=0 and halted=1; all inputs SHALL be ignored and only reset exits HALT.
REQ-023 PC arithmetic SHALL be modulo 2^16, so 16'hFFFF+1 wraps to 16'h0000 with no flag.
REQ-024 branch_count SHALL increment by 1 on each accepted redirect and saturate at 16'hFFFF.
REQ-025 A redirect and a halt in the same RUN cycle SHALL take the redirect and drop the halt, because the halting instruction is younger and is squashed.
REQ-026 halted SHALL be high exactly while the state is HALT.

Reset
REQ-027 While reset=1, asynchronously and independent of clk:
- pc=RESET_PC, flush=0, halted=0, branch_count=0.
- state=RUN, flush counter=0.
REQ-028 Reset asserted mid-FLUSH or in HALT SHALL abort that state immediately; the first edge after deassertion SHALL behave as RUN.

Verification
REQ-029 Reset, then 4 cycles with stall=0 and no jumps -> pc sequence 0,1,2,3,4; flush=0; halted=0.
REQ-030 At pc=5, pulse is_jmp_op=1, taken=1, jmp_target=16'h0040 -> pc=0x40 and flush=1 next cycle, flush=1 for 2 cycles, pc 0x40,0x41,0x42, branch_count=1.
REQ-031 Redirect followed by stall=1 for 3 cycles inside FLUSH -> pc and flush held during the stall, flush then high for 1 more advancing cycle; while in FLUSH a second redirect is ignored and branch_count stays 1.
REQ-032 is_jmp_op=1, taken=0, then is_jmp_op=0, taken=1 -> no redirect, pc increments normally, branch_count unchanged.
REQ-033 halt=1 together with a redirect -> redirect taken, no halt; later halt=1 alone -> halted=1 and pc frozen across 10 cycles including jump inputs; reset asserted mid-cycle -> pc=0 and halted=0 without waiting for a clock edge.
REQ-034 Force pc to 16'hFFFE via redirect, then advance -> pc 0xFFFE,0xFFFF,0x0000 after flush completes; 65536 redirects -> branch_count saturates at 16'hFFFF.
